// File: rtl/saturation_monitor_pkg.sv
// Shared definitions for the saturation monitor slice.
//   DEF_DATA_WIDTH / DEF_CNT_WIDTH : default sample and counter widths
//   CNT_MAX                        : saturation ceiling of a default-width counter
//   pol_e                          : clip polarity, taken from the sample sign bit
package saturation_monitor_pkg;

    localparam int unsigned DEF_DATA_WIDTH = 16;
    localparam int unsigned DEF_CNT_WIDTH  = 16;

    localparam logic [DEF_CNT_WIDTH-1:0] CNT_MAX = '1;

    typedef enum logic {
        POL_POS = 1'b0,
        POL_NEG = 1'b1
    } pol_e;

endpackage

// File: rtl/saturation_monitor_if.sv
// Bundle of the monitor's sample input, configuration and status outputs.
//   master : sample source / register interface (drives inputs, reads status)
//   slave  : the monitor itself
interface saturation_monitor_if
    import saturation_monitor_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = DEF_DATA_WIDTH,
    parameter int unsigned CNT_WIDTH  = DEF_CNT_WIDTH
);
    logic                  in_valid;
    logic [DATA_WIDTH-1:0] in_data;
    logic                  in_sat;
    logic [CNT_WIDTH-1:0]  window_len;
    logic [CNT_WIDTH-1:0]  alarm_threshold;
    logic                  clear;

    logic [CNT_WIDTH-1:0]  sat_count;
    logic [CNT_WIDTH-1:0]  window_sat_count;
    logic                  window_done;
    logic [CNT_WIDTH-1:0]  run_max;
    logic                  sticky_pos;
    logic                  sticky_neg;
    logic                  alarm;

    modport master (
        output in_valid, in_data, in_sat, window_len, alarm_threshold, clear,
        input  sat_count, window_sat_count, window_done, run_max,
               sticky_pos, sticky_neg, alarm
    );

    modport slave (
        input  in_valid, in_data, in_sat, window_len, alarm_threshold, clear,
        output sat_count, window_sat_count, window_done, run_max,
               sticky_pos, sticky_neg, alarm
    );
endinterface

// File: rtl/saturation_monitor_sat_counter.sv
// Saturating up-counter with synchronous clear and load-zero.
//   clk, reset    : clock, asynchronous active-high reset
//   i_clr         : synchronous clear (highest priority)
//   i_load_zero   : restart from zero; i_inc is applied on top of the zero
//   i_inc         : increment request
//   o_count       : registered count
//   o_plus1       : o_count + 1, held at the ceiling (combinational look-ahead)
module sat_counter
    import saturation_monitor_pkg::*;
#(
    parameter int unsigned WIDTH = DEF_CNT_WIDTH
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             i_clr,
    input  logic             i_load_zero,
    input  logic             i_inc,
    output logic [WIDTH-1:0] o_count,
    output logic [WIDTH-1:0] o_plus1
);
    logic [WIDTH-1:0] r_count;
    logic [WIDTH-1:0] w_base;
    logic [WIDTH-1:0] w_next;

    always_comb begin
        o_plus1 = (r_count == '1) ? r_count : r_count + WIDTH'(1);
        w_base  = i_load_zero ? '0 : r_count;
        w_next  = w_base;
        if (i_clr) begin
            w_next = '0;
        end else if (i_inc && (w_base != '1)) begin
            w_next = w_base + WIDTH'(1);
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_count <= '0;
        end else begin
            r_count <= w_next;
        end
    end

    assign o_count = r_count;
endmodule

// File: rtl/saturation_monitor.sv
// Saturation monitor: counts clipped samples per window, tracks the longest
// same-polarity clip run, keeps sticky polarity flags and a run-length alarm.
//   clk, reset : clock, asynchronous active-high reset
//   bus        : sample input, window/alarm configuration, clear and status
module saturation_monitor
    import saturation_monitor_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = DEF_DATA_WIDTH,
    parameter int unsigned CNT_WIDTH  = DEF_CNT_WIDTH
) (
    input  logic                 clk,
    input  logic                 reset,
    saturation_monitor_if.slave  bus
);
    logic                 w_accept;
    logic                 w_sat;
    pol_e                 w_pol;
    logic                 w_win_en;
    logic                 w_close;
    logic                 w_continue;
    logic [CNT_WIDTH-1:0] w_run_upd;

    logic [CNT_WIDTH-1:0] w_idx_count, w_idx_plus1;
    logic [CNT_WIDTH-1:0] w_sat_count, w_sat_plus1;
    logic [CNT_WIDTH-1:0] w_run_count, w_run_plus1;

    pol_e                 r_run_pol;
    logic [CNT_WIDTH-1:0] r_run_max;
    logic [CNT_WIDTH-1:0] r_window_sat_count;
    logic                 r_window_done;
    logic                 r_sticky_pos;
    logic                 r_sticky_neg;
    logic                 r_alarm;

    always_comb begin
        // clear wins over a coincident sample
        w_accept   = bus.in_valid & ~bus.clear;
        w_sat      = w_accept & bus.in_sat;
        w_pol      = pol_e'(bus.in_data[DATA_WIDTH-1]);
        w_win_en   = (bus.window_len != '0);
        // index+1 >= len also closes immediately when len was lowered mid-window
        w_close    = w_accept & w_win_en & (w_idx_plus1 >= bus.window_len);
        // a nonzero run implies the previous valid sample was saturated
        w_continue = (w_run_count != '0) & (r_run_pol == w_pol);
        w_run_upd  = '0;
        if (bus.in_sat) begin
            w_run_upd = w_continue ? w_run_plus1 : CNT_WIDTH'(1);
        end
    end

    sat_counter #(.WIDTH(CNT_WIDTH)) u_idx_cnt (
        .clk         (clk),
        .reset       (reset),
        .i_clr       (bus.clear),
        .i_load_zero (w_accept & (w_close | (~w_win_en & (w_idx_count != '0)))),
        .i_inc       (w_accept & w_win_en & ~w_close),
        .o_count     (w_idx_count),
        .o_plus1     (w_idx_plus1)
    );

    sat_counter #(.WIDTH(CNT_WIDTH)) u_sat_cnt (
        .clk         (clk),
        .reset       (reset),
        .i_clr       (bus.clear),
        .i_load_zero (w_close),
        .i_inc       (w_sat & ~w_close),
        .o_count     (w_sat_count),
        .o_plus1     (w_sat_plus1)
    );

    sat_counter #(.WIDTH(CNT_WIDTH)) u_run_cnt (
        .clk         (clk),
        .reset       (reset),
        .i_clr       (bus.clear),
        .i_load_zero (w_accept & ~(bus.in_sat & w_continue)),
        .i_inc       (w_sat),
        .o_count     (w_run_count),
        .o_plus1     (w_run_plus1)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_run_pol          <= POL_POS;
            r_run_max          <= '0;
            r_window_sat_count <= '0;
            r_window_done      <= 1'b0;
            r_sticky_pos       <= 1'b0;
            r_sticky_neg       <= 1'b0;
            r_alarm            <= 1'b0;
        end else if (bus.clear) begin
            r_run_pol          <= POL_POS;
            r_run_max          <= '0;
            r_window_sat_count <= '0;
            r_window_done      <= 1'b0;
            r_sticky_pos       <= 1'b0;
            r_sticky_neg       <= 1'b0;
            r_alarm            <= 1'b0;
        end else begin
            r_window_done <= w_close;
            if (w_accept) begin
                if (bus.in_sat) begin
                    r_run_pol <= w_pol;
                    if (w_pol == POL_NEG) r_sticky_neg <= 1'b1;
                    else                  r_sticky_pos <= 1'b1;
                end
                if (w_run_upd > r_run_max) begin
                    r_run_max <= w_run_upd;
                end
                if ((bus.alarm_threshold != '0) && (w_run_upd >= bus.alarm_threshold)) begin
                    r_alarm <= 1'b1;
                end
                if (w_close) begin
                    r_window_sat_count <= bus.in_sat ? w_sat_plus1 : w_sat_count;
                end
            end
        end
    end

    assign bus.sat_count        = w_sat_count;
    assign bus.window_sat_count = r_window_sat_count;
    assign bus.window_done      = r_window_done;
    assign bus.run_max          = r_run_max;
    assign bus.sticky_pos       = r_sticky_pos;
    assign bus.sticky_neg       = r_sticky_neg;
    assign bus.alarm            = r_alarm;
endmodule

// File: tb/tb_saturation_monitor.sv
module tb_saturation_monitor;
    localparam int DW   = 16;
    localparam int CW   = 16;
    localparam int MAXV = (1 << CW) - 1;

    logic clk   = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    saturation_monitor_if #(.DATA_WIDTH(DW), .CNT_WIDTH(CW)) bus ();
    saturation_monitor_if #(.DATA_WIDTH(DW), .CNT_WIDTH(4))  bus4 ();

    saturation_monitor #(.DATA_WIDTH(DW), .CNT_WIDTH(CW)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    saturation_monitor #(.DATA_WIDTH(DW), .CNT_WIDTH(4)) dut4 (
        .clk   (clk),
        .reset (reset),
        .bus   (bus4)
    );

    int n_checks = 0;
    int n_pass   = 0;

    typedef struct {
        int sc, wsc, rmax;
        bit done, sp, sn, al;
    } exp_t;
    exp_t sb[$];

    // reference model: history of accepted samples since clear
    bit m_hist_sat[$];
    bit m_hist_pol[$];
    bit m_win[$];
    int m_pos, m_rmax, m_wsc;
    bit m_sp, m_sn, m_al, m_done;

    function automatic int win_sats();
        int s = 0;
        foreach (m_win[i]) s += m_win[i];
        return (s > MAXV) ? MAXV : s;
    endfunction

    function automatic int trailing_run();
        int n = 0;
        int last = m_hist_sat.size() - 1;
        if (last < 0) return 0;
        if (!m_hist_sat[last]) return 0;
        for (int i = last; i >= 0; i--) begin
            if (!m_hist_sat[i] || (m_hist_pol[i] != m_hist_pol[last])) break;
            n++;
            if (n == MAXV) break;
        end
        return n;
    endfunction

    task automatic model_reset();
        m_hist_sat.delete(); m_hist_pol.delete(); m_win.delete();
        m_pos = 0; m_rmax = 0; m_wsc = 0;
        m_sp = 0; m_sn = 0; m_al = 0; m_done = 0;
    endtask

    task automatic model_step(input bit v, input logic [DW-1:0] d, input bit s,
                              input bit clr, input int wl, input int thr);
        int run;
        bit close;
        m_done = 0;
        if (clr) begin
            model_reset();
        end else if (v) begin
            m_hist_sat.push_back(s);
            m_hist_pol.push_back(d[DW-1]);
            run = trailing_run();
            m_win.push_back(s);
            close = (wl != 0) && (m_pos + 1 >= wl);
            if (run > m_rmax) m_rmax = run;
            if (s && d[DW-1])  m_sn = 1;
            if (s && !d[DW-1]) m_sp = 1;
            if (thr != 0 && run >= thr) m_al = 1;
            if (close) begin
                m_wsc = win_sats();
                m_win.delete();
                m_pos = 0;
                m_done = 1;
            end else begin
                m_pos = (wl == 0) ? 0 : m_pos + 1;
            end
        end
    endtask

    task automatic chk(input string name, input int act, input int exp_v);
        n_checks++;
        if (act == exp_v) n_pass++;
        else $display("FAIL %s: got %0d expected %0d", name, act, exp_v);
    endtask

    task automatic chk_all_zero(input string name);
        chk({name, ".sat_count"}, int'(bus.sat_count), 0);
        chk({name, ".window_sat_count"}, int'(bus.window_sat_count), 0);
        chk({name, ".window_done"}, int'(bus.window_done), 0);
        chk({name, ".run_max"}, int'(bus.run_max), 0);
        chk({name, ".sticky_pos"}, int'(bus.sticky_pos), 0);
        chk({name, ".sticky_neg"}, int'(bus.sticky_neg), 0);
        chk({name, ".alarm"}, int'(bus.alarm), 0);
    endtask

    // drive one cycle; model is advanced at the edge that applies the inputs
    task automatic step(input bit v, input logic [DW-1:0] d, input bit s, input bit clr);
        exp_t e;
        bus.in_valid = v; bus.in_data = d; bus.in_sat = s; bus.clear = clr;
        @(posedge clk);
        model_step(v, d, s, clr, int'(bus.window_len), int'(bus.alarm_threshold));
        e.sc = win_sats(); e.wsc = m_wsc; e.rmax = m_rmax;
        e.done = m_done; e.sp = m_sp; e.sn = m_sn; e.al = m_al;
        sb.push_back(e);
        @(negedge clk);
        #1;
        bus.in_valid = 0; bus.clear = 0; bus.in_sat = 0;
    endtask

    // monitor: compares the DUT status against the oldest expectation
    always @(negedge clk) begin
        if (sb.size() != 0) begin
            exp_t e;
            e = sb.pop_front();
            n_checks++;
            if (int'(bus.sat_count) == e.sc && int'(bus.window_sat_count) == e.wsc &&
                int'(bus.run_max) == e.rmax && bus.window_done == e.done &&
                bus.sticky_pos == e.sp && bus.sticky_neg == e.sn && bus.alarm == e.al) begin
                n_pass++;
            end else begin
                $display("FAIL scoreboard @%0t: got sc=%0d wsc=%0d rmax=%0d done=%0b sp=%0b sn=%0b al=%0b expected sc=%0d wsc=%0d rmax=%0d done=%0b sp=%0b sn=%0b al=%0b",
                         $time, bus.sat_count, bus.window_sat_count, bus.run_max, bus.window_done,
                         bus.sticky_pos, bus.sticky_neg, bus.alarm,
                         e.sc, e.wsc, e.rmax, e.done, e.sp, e.sn, e.al);
            end
        end
    end

    localparam logic [DW-1:0] POS = 16'h7FFF;
    localparam logic [DW-1:0] NEG = 16'h8000;
    localparam logic [DW-1:0] MID = 16'h1234;

    initial begin
        bit seen_done;
        logic [DW-1:0] d;
        bit sign;
        model_reset();
        bus.in_valid = 0; bus.in_data = '0; bus.in_sat = 0; bus.clear = 0;
        bus.window_len = '0; bus.alarm_threshold = '0;
        bus4.in_valid = 0; bus4.in_data = '0; bus4.in_sat = 0; bus4.clear = 0;
        bus4.window_len = '0; bus4.alarm_threshold = '0;

        #3;
        chk_all_zero("reset");
        @(negedge clk); #1;
        reset = 0;

        // window of 4: sat pattern 1,0,1,1, all positive
        bus.window_len = 16'd4;
        step(1, POS, 1, 0);
        step(1, MID, 0, 0);
        step(1, POS, 1, 0);
        step(1, POS, 1, 0);
        chk("win4.done", int'(bus.window_done), 1);
        chk("win4.window_sat_count", int'(bus.window_sat_count), 3);
        chk("win4.sat_count", int'(bus.sat_count), 0);
        chk("win4.run_max", int'(bus.run_max), 2);
        chk("win4.sticky_pos", int'(bus.sticky_pos), 1);
        chk("win4.sticky_neg", int'(bus.sticky_neg), 0);
        step(0, MID, 0, 0);
        chk("win4.done_pulse_len", int'(bus.window_done), 0);

        // polarity runs + + - - - with threshold 3
        step(0, MID, 0, 1);
        bus.window_len = '0; bus.alarm_threshold = 16'd3;
        step(1, POS, 1, 0);
        step(1, POS, 1, 0);
        step(1, NEG, 1, 0);
        step(1, NEG, 1, 0);
        chk("runs.alarm_before", int'(bus.alarm), 0);
        step(1, NEG, 1, 0);
        chk("runs.alarm_after", int'(bus.alarm), 1);
        step(1, MID, 0, 0);
        step(1, MID, 0, 0);
        chk("runs.alarm_sticky", int'(bus.alarm), 1);
        chk("runs.run_max", int'(bus.run_max), 3);
        chk("runs.sticky_both", int'(bus.sticky_pos & bus.sticky_neg), 1);

        // clear with a coincident saturated sample
        step(1, POS, 1, 1);
        chk_all_zero("clear_prio");

        // window_len lowered from 10 to 2 after 5 samples
        bus.window_len = 16'd10; bus.alarm_threshold = '0;
        for (int i = 0; i < 5; i++) step(1, MID, 0, 0);
        bus.window_len = 16'd2;
        step(1, POS, 1, 0);
        chk("lower_len.done", int'(bus.window_done), 1);

        // asynchronous reset mid-window
        bus.window_len = 16'd4;
        step(0, MID, 0, 1);
        for (int i = 0; i < 3; i++) step(1, POS, 1, 0);
        #1 reset = 1;
        #1 chk_all_zero("async_reset");
        model_reset();
        @(posedge clk); @(negedge clk); #1;
        reset = 0;
        for (int i = 0; i < 3; i++) step(1, MID, 0, 0);
        chk("post_reset.no_early_done", int'(bus.window_done), 0);
        step(1, MID, 0, 0);
        chk("post_reset.done", int'(bus.window_done), 1);

        // randomized traffic against the model
        sign = 0;
        for (int i = 0; i < 1500; i++) begin
            if ($urandom_range(0, 19) == 0) begin
                bus.window_len      = 16'($urandom_range(0, 6));
                bus.alarm_threshold = 16'($urandom_range(0, 5));
            end
            if ($urandom_range(0, 4) == 0) sign = ~sign;
            d = 16'($urandom);
            d[DW-1] = sign;
            step($urandom_range(0, 3) != 0, d, $urandom_range(0, 2) != 0,
                 $urandom_range(0, 39) == 0);
        end

        // narrow counters: saturation without windowing
        seen_done = 0;
        bus4.in_valid = 1; bus4.in_sat = 1; bus4.in_data = POS;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (bus4.window_done) seen_done = 1;
        end
        #1 bus4.in_valid = 0;
        chk("cnt4.no_done", int'(seen_done), 0);
        chk("cnt4.sat_count", int'(bus4.sat_count), 15);
        chk("cnt4.run_max", int'(bus4.run_max), 15);

        @(negedge clk); #1;
        n_checks++;
        if (sb.size() == 0) n_pass++;
        else $display("FAIL scoreboard_drain: got %0d pending expected 0", sb.size());

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
